// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BTP_TAG_CHECK_EN to store partial PC tags and require a tag match on hit.
module branch_target_predictor #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ENTRIES    = 8,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_if_pc,
    output logic                  o_prediction,
    output logic [DATA_WIDTH-1:0] o_target,
    input  logic                  i_upd_valid,
    input  logic                  i_upd_is_branch,
    input  logic [DATA_WIDTH-1:0] i_upd_pc,
    input  logic                  i_upd_taken,
    input  logic [DATA_WIDTH-1:0] i_upd_target,
    input  logic                  i_upd_pred,
    input  logic                  i_flush_all,
    output logic                  o_mispredict
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    logic [ENTRIES-1:0]    valid_q;
    logic [1:0]            ctr_q [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_q [ENTRIES];
    logic                  mispredict_q;

    logic [IDX-1:0] if_idx;
    logic [IDX-1:0] upd_idx;
    logic           if_hit;
    logic           upd_hit;

    assign if_idx  = i_if_pc[IDX+1:2];
    assign upd_idx = i_upd_pc[IDX+1:2];

`ifdef BTP_TAG_CHECK_EN
    logic [TAG_WIDTH-1:0] tag_q [ENTRIES];
    logic [TAG_WIDTH-1:0] if_tag;
    logic [TAG_WIDTH-1:0] upd_tag;

    assign if_tag  = i_if_pc[IDX+2+TAG_WIDTH-1:IDX+2];
    assign upd_tag = i_upd_pc[IDX+2+TAG_WIDTH-1:IDX+2];
    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) tag_q[i] <= '0;
        end else if (!i_flush_all && i_upd_valid && !upd_hit && i_upd_taken) begin
            tag_q[upd_idx] <= upd_tag;
        end
    end
`else
    // Untagged: PCs that share an index alias onto the same entry.
    logic [TAG_WIDTH-1:0] unused_tag;
    assign unused_tag = i_if_pc[IDX+2+TAG_WIDTH-1:IDX+2] ^ i_upd_pc[IDX+2+TAG_WIDTH-1:IDX+2];
    assign if_hit     = valid_q[if_idx];
    assign upd_hit    = valid_q[upd_idx];
`endif

    logic unused_pc;
    assign unused_pc = ^{i_if_pc, i_upd_pc};

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    assign o_prediction = if_hit && ctr_q[if_idx][1];
    assign o_target     = o_prediction ? tgt_q[if_idx] : '0;
    assign o_mispredict = mispredict_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q      <= '0;
            mispredict_q <= 1'b0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= 2'b01;
                tgt_q[i] <= '0;
            end
        end else begin
            mispredict_q <= i_upd_valid && (i_upd_pred ^ i_upd_taken);
            if (i_flush_all) begin
                valid_q <= '0;
            end else if (i_upd_valid) begin
                if (upd_hit) begin
                    if (i_upd_taken) begin
                        tgt_q[upd_idx] <= i_upd_target;
                        if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                    end else if (ctr_q[upd_idx] != 2'b00) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                    end
                end else if (i_upd_taken) begin
                    valid_q[upd_idx] <= 1'b1;
                    tgt_q[upd_idx]   <= i_upd_target;
                    ctr_q[upd_idx]   <= i_upd_is_branch ? 2'b10 : 2'b11;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor (default parameters, ENTRIES=8).
// Alias expectations follow BTP_TAG_CHECK_EN when it is defined for the build.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        prediction;
    logic [31:0] target;
    logic        upd_valid;
    logic        upd_is_branch;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred;
    logic        flush_all;
    logic        mispredict;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    branch_target_predictor dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_if_pc         (if_pc),
        .o_prediction    (prediction),
        .o_target        (target),
        .i_upd_valid     (upd_valid),
        .i_upd_is_branch (upd_is_branch),
        .i_upd_pc        (upd_pc),
        .i_upd_taken     (upd_taken),
        .i_upd_target    (upd_target),
        .i_upd_pred      (upd_pred),
        .i_flush_all     (flush_all),
        .o_mispredict    (mispredict)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One update presented for a single edge.
    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic br, input logic pred);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_taken     = taken;
        upd_target    = tgt;
        upd_is_branch = br;
        upd_pred      = pred;
        tick();
        upd_valid     = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_pred,
                          input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check_eq({tag, "_pred"}, {31'd0, prediction}, {31'd0, exp_pred});
        check_eq({tag, "_tgt"}, target, exp_tgt);
    endtask

    task automatic flush();
        flush_all = 1'b1;
        tick();
        flush_all = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_is_branch = 1'b1; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pred = 1'b0; flush_all = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        lookup("reset", 32'h10, 1'b0, 32'h0);
        check_eq("reset_mispredict", {31'd0, mispredict}, 32'd0);

        // Allocate a branch at counter 10, then one not-taken drops it to 01.
        update(32'h10, 1'b1, 32'h40, 1'b1, 1'b0);
        lookup("alloc", 32'h10, 1'b1, 32'h40);
        update(32'h10, 1'b0, 32'h0, 1'b1, 1'b1);
        lookup("dec", 32'h10, 1'b0, 32'h0);
        check_eq("mispredict_set", {31'd0, mispredict}, 32'd1);
        tick();
        check_eq("mispredict_clear", {31'd0, mispredict}, 32'd0);

        // Saturation: four taken then two not-taken from an empty entry.
        flush();
        update(32'h10, 1'b1, 32'h40, 1'b1, 1'b0);
        lookup("sat_t1", 32'h10, 1'b1, 32'h40);
        update(32'h10, 1'b1, 32'h40, 1'b1, 1'b1);
        lookup("sat_t2", 32'h10, 1'b1, 32'h40);
        update(32'h10, 1'b1, 32'h40, 1'b1, 1'b1);
        lookup("sat_t3", 32'h10, 1'b1, 32'h40);
        update(32'h10, 1'b1, 32'h80, 1'b1, 1'b1);
        lookup("sat_t4", 32'h10, 1'b1, 32'h80);
        update(32'h10, 1'b0, 32'h0, 1'b1, 1'b1);
        lookup("sat_n1", 32'h10, 1'b1, 32'h80);
        update(32'h10, 1'b0, 32'h0, 1'b1, 1'b1);
        lookup("sat_n2", 32'h10, 1'b0, 32'h0);

        // Counter 01 -> 00 -> 00 stays valid; taken climbs back to 01, not reallocated to 10.
        update(32'h10, 1'b0, 32'h0, 1'b1, 1'b0);
        update(32'h10, 1'b0, 32'h0, 1'b1, 1'b0);
        update(32'h10, 1'b1, 32'h84, 1'b1, 1'b0);
        lookup("no_evict", 32'h10, 1'b0, 32'h0);
        update(32'h10, 1'b1, 32'h84, 1'b1, 1'b0);
        lookup("climb", 32'h10, 1'b1, 32'h84);

        // 0x30 shares index 4 with 0x10 but has a different tag.
`ifdef BTP_TAG_CHECK_EN
        lookup("alias", 32'h30, 1'b0, 32'h0);
`else
        lookup("alias", 32'h30, 1'b1, 32'h84);
`endif

        // Jumps allocate at 11, so one not-taken still predicts taken.
        flush();
        lookup("flush", 32'h10, 1'b0, 32'h0);
        update(32'h08, 1'b1, 32'h100, 1'b0, 1'b0);
        update(32'h08, 1'b0, 32'h0, 1'b0, 1'b1);
        lookup("jump", 32'h08, 1'b1, 32'h100);

        // Not-taken miss must not allocate.
        update(32'h0c, 1'b0, 32'h55, 1'b1, 1'b0);
        lookup("no_alloc", 32'h0c, 1'b0, 32'h0);

        // Same-cycle lookup and update of 0x20 on an empty index.
        if_pc = 32'h20;
        upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h200;
        upd_is_branch = 1'b1; upd_pred = 1'b0;
        #1;
        check_eq("bypass_same", {31'd0, prediction}, 32'd0);
        tick();
        upd_valid = 1'b0;
        lookup("bypass_next", 32'h20, 1'b1, 32'h200);

        // Flush wins over a simultaneous update.
        flush_all = 1'b1;
        update(32'h24, 1'b1, 32'h300, 1'b1, 1'b0);
        flush_all = 1'b0;
        lookup("flush_upd_a", 32'h20, 1'b0, 32'h0);
        lookup("flush_upd_b", 32'h24, 1'b0, 32'h0);
        lookup("flush_upd_c", 32'h08, 1'b0, 32'h0);

        // Reset mid-sequence overrides a concurrent update and mispredict.
        update(32'h10, 1'b1, 32'h40, 1'b1, 1'b0);
        lookup("pre_rst", 32'h10, 1'b1, 32'h40);
        rst_n = 1'b0;
        update(32'h14, 1'b1, 32'h44, 1'b1, 1'b0);
        rst_n = 1'b1;
        lookup("rst_a", 32'h10, 1'b0, 32'h0);
        lookup("rst_b", 32'h14, 1'b0, 32'h0);
        check_eq("rst_mispredict", {31'd0, mispredict}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
